// File: rtl/led_pattern_decoder_if.sv
// LED observation bus: the RGB vectors watched by the decoder plus its decoded status.
interface led_pattern_decoder_if #(
    parameter int unsigned NB_LED = 4,
    parameter int unsigned NB_CNT = 32
);
    logic [NB_LED-1:0] i_led_r;
    logic [NB_LED-1:0] i_led_g;
    logic [NB_LED-1:0] i_led_b;
    logic [1:0]        o_mode;
    logic [1:0]        o_color;
    logic [NB_CNT-1:0] o_period;
    logic              o_locked;
    logic              o_valid;

    modport master (
        output i_led_r, i_led_g, i_led_b,
        input  o_mode, o_color, o_period, o_locked, o_valid
    );

    modport slave (
        input  i_led_r, i_led_g, i_led_b,
        output o_mode, o_color, o_period, o_locked, o_valid
    );
endinterface

// File: rtl/led_pattern_decoder.sv
// Decodes the pattern (shift-left/right, flash), colour and step period driven on the RGB LEDs,
// locking once the same step class and period repeat N_CONFIRM times.
module led_pattern_decoder #(
    parameter int unsigned NB_LED    = 4,
    parameter int unsigned NB_CNT    = 32,
    parameter int unsigned N_CONFIRM = 2
) (
    input  logic                  clock,
    input  logic                  i_reset,
    led_pattern_decoder_if.slave  led
);
    localparam int unsigned M_W = $clog2(N_CONFIRM + 1);

    typedef enum logic [1:0] {
        CLS_OTHER = 2'd0,
        CLS_LEFT  = 2'd1,
        CLS_RIGHT = 2'd2,
        CLS_FLASH = 2'd3
    } cls_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    logic [NB_LED-1:0] r_q, g_q, b_q;
    logic [NB_LED-1:0] v_q, v_qq;
    logic [NB_CNT-1:0] cnt_q;
    logic [NB_CNT-1:0] ref_period_q;
    cls_e              ref_cls_q;
    logic [M_W-1:0]    m_q;
    state_e            state_q;
    logic [1:0]        mode_q;
    logic [1:0]        color_q;
    logic [NB_CNT-1:0] period_q;
    logic              locked_q;
    logic              valid_q;

    logic [NB_LED-1:0] rotl_c, rotr_c;
    logic              step_c;
    logic              match_c;
    logic              sat_c;
    cls_e              cls_c;

    // Classify the transition v_qq -> v_q; flash accepts either edge of the all-on/all-off toggle.
    always_comb begin
        rotl_c  = (v_qq << 1) | (v_qq >> (NB_LED - 1));
        rotr_c  = (v_qq >> 1) | (v_qq << (NB_LED - 1));
        step_c  = (v_q != v_qq);
        sat_c   = (cnt_q == '1);
        cls_c   = CLS_OTHER;
        if ((v_qq == '0 && v_q == '1) || (v_qq == '1 && v_q == '0)) begin
            cls_c = CLS_FLASH;
        end else if (v_q == rotl_c) begin
            cls_c = CLS_LEFT;
        end else if (v_q == rotr_c) begin
            cls_c = CLS_RIGHT;
        end
        match_c = (cls_c == ref_cls_q) && (cls_c != CLS_OTHER) && (cnt_q == ref_period_q);
    end

    always_ff @(posedge clock) begin
        if (!i_reset) begin
            r_q          <= '0;
            g_q          <= '0;
            b_q          <= '0;
            v_q          <= '0;
            v_qq         <= '0;
            cnt_q        <= '0;
            ref_period_q <= '0;
            ref_cls_q    <= CLS_OTHER;
            m_q          <= '0;
            state_q      <= ST_IDLE;
            mode_q       <= '0;
            color_q      <= '0;
            period_q     <= '0;
            locked_q     <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            r_q     <= led.i_led_r;
            g_q     <= led.i_led_g;
            b_q     <= led.i_led_b;
            v_q     <= led.i_led_r | led.i_led_g | led.i_led_b;
            v_qq    <= v_q;
            valid_q <= 1'b0;

            if (r_q != '0) begin
                color_q <= 2'd1;
            end else if (g_q != '0) begin
                color_q <= 2'd2;
            end else if (b_q != '0) begin
                color_q <= 2'd3;
            end

            if (step_c) begin
                period_q <= cnt_q;
                cnt_q    <= NB_CNT'(1);
            end else if (!sat_c) begin
                cnt_q <= cnt_q + NB_CNT'(1);
            end

            // A step takes priority over counter saturation.
            if (step_c) begin
                unique case (state_q)
                    ST_IDLE: begin
                        ref_cls_q    <= cls_c;
                        ref_period_q <= cnt_q;
                        m_q          <= '0;
                        state_q      <= ST_SEARCH;
                    end
                    ST_SEARCH: begin
                        if (match_c) begin
                            m_q <= m_q + M_W'(1);
                            if (32'(m_q) + 32'd1 == N_CONFIRM) begin
                                state_q  <= ST_LOCKED;
                                locked_q <= 1'b1;
                                mode_q   <= cls_c;
                            end
                        end else begin
                            ref_cls_q    <= cls_c;
                            ref_period_q <= cnt_q;
                            m_q          <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (match_c) begin
                            valid_q <= 1'b1;
                        end else begin
                            ref_cls_q    <= cls_c;
                            ref_period_q <= cnt_q;
                            m_q          <= '0;
                            state_q      <= ST_SEARCH;
                            locked_q     <= 1'b0;
                            mode_q       <= '0;
                        end
                    end
                    default: begin
                        state_q  <= ST_IDLE;
                        locked_q <= 1'b0;
                        mode_q   <= '0;
                    end
                endcase
            end else if (sat_c) begin
                state_q  <= ST_IDLE;
                locked_q <= 1'b0;
                mode_q   <= '0;
            end
        end
    end

    assign led.o_mode   = mode_q;
    assign led.o_color  = color_q;
    assign led.o_period = period_q;
    assign led.o_locked = locked_q;
    assign led.o_valid  = valid_q;
endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed bench for led_pattern_decoder: reset, shift-left/right, flash, period change, timeout, mid-lock reset.
module tb_led_pattern_decoder;
    logic clock;
    logic i_reset;
    int   total = 0;
    int   bad   = 0;

    led_pattern_decoder_if #(.NB_LED(4), .NB_CNT(8)) bus ();

    led_pattern_decoder #(
        .NB_LED   (4),
        .NB_CNT   (8),
        .N_CONFIRM(2)
    ) dut (
        .clock  (clock),
        .i_reset(i_reset),
        .led    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        bus.i_led_r = r;
        bus.i_led_g = g;
        bus.i_led_b = b;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        drive(4'h0, 4'h0, 4'h0);
        tick(2);
        i_reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset held 3 cycles with LEDs toggling
        i_reset = 1'b0;
        drive(4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            drive(4'(i + 1), 4'(i + 5), 4'hF);
            tick(1);
            chk("rst_valid", 32'(bus.o_valid), 0);
        end
        chk("rst_locked", 32'(bus.o_locked), 0);
        chk("rst_mode",   32'(bus.o_mode),   0);
        chk("rst_color",  32'(bus.o_color),  0);
        chk("rst_period", 32'(bus.o_period), 0);
        drive(4'h0, 4'h0, 4'h0);
        tick(1);
        i_reset = 1'b1;

        // Red shift-left, period 10
        drive(4'b0001, 4'h0, 4'h0); tick(10);
        drive(4'b0010, 4'h0, 4'h0); tick(10);
        drive(4'b0100, 4'h0, 4'h0); tick(2);
        chk("red_prelock", 32'(bus.o_locked), 0);
        tick(8);
        drive(4'b1000, 4'h0, 4'h0); tick(2);
        chk("red_locked", 32'(bus.o_locked), 1);
        chk("red_mode",   32'(bus.o_mode),   1);
        chk("red_color",  32'(bus.o_color),  1);
        chk("red_period", 32'(bus.o_period), 10);
        chk("red_novalid_at_lock", 32'(bus.o_valid), 0);
        tick(8);
        drive(4'b0001, 4'h0, 4'h0); tick(2);
        chk("red_valid1", 32'(bus.o_valid), 1);
        tick(1);
        chk("red_valid1_end", 32'(bus.o_valid), 0);
        tick(7);
        drive(4'b0010, 4'h0, 4'h0); tick(2);
        chk("red_valid2", 32'(bus.o_valid), 1);
        tick(1);
        chk("red_valid2_end", 32'(bus.o_valid), 0);

        // Freeze LEDs: counter saturates at 255 and the lock drops
        tick(253);
        chk("tmo_before", 32'(bus.o_locked), 1);
        tick(1);
        chk("tmo_locked", 32'(bus.o_locked), 0);
        chk("tmo_mode",   32'(bus.o_mode),   0);
        chk("tmo_period", 32'(bus.o_period), 10);
        chk("tmo_color",  32'(bus.o_color),  1);

        // Blue flash, period 6
        do_reset();
        drive(4'h0, 4'h0, 4'hF); tick(6);
        drive(4'h0, 4'h0, 4'h0); tick(6);
        drive(4'h0, 4'h0, 4'hF); tick(2);
        chk("blu_prelock", 32'(bus.o_locked), 0);
        chk("blu_color_on", 32'(bus.o_color), 3);
        tick(4);
        drive(4'h0, 4'h0, 4'h0); tick(2);
        chk("blu_locked", 32'(bus.o_locked), 1);
        chk("blu_mode",   32'(bus.o_mode),   3);
        chk("blu_period", 32'(bus.o_period), 6);
        chk("blu_color_off", 32'(bus.o_color), 3);

        // Green shift-right at period 10, then period 12
        do_reset();
        drive(4'h0, 4'b1000, 4'h0); tick(10);
        drive(4'h0, 4'b0100, 4'h0); tick(10);
        drive(4'h0, 4'b0010, 4'h0); tick(2);
        chk("grn_prelock", 32'(bus.o_locked), 0);
        tick(8);
        drive(4'h0, 4'b0001, 4'h0); tick(2);
        chk("grn_locked", 32'(bus.o_locked), 1);
        chk("grn_mode",   32'(bus.o_mode),   2);
        chk("grn_color",  32'(bus.o_color),  2);
        chk("grn_period", 32'(bus.o_period), 10);
        tick(8);
        drive(4'h0, 4'b1000, 4'h0); tick(2);
        chk("grn_valid", 32'(bus.o_valid), 1);
        tick(10);
        drive(4'h0, 4'b0100, 4'h0); tick(2);
        chk("p12_unlock", 32'(bus.o_locked), 0);
        chk("p12_mode",   32'(bus.o_mode),   0);
        chk("p12_valid",  32'(bus.o_valid),  0);
        chk("p12_period", 32'(bus.o_period), 12);
        tick(10);
        drive(4'h0, 4'b0010, 4'h0); tick(2);
        chk("p12_search", 32'(bus.o_locked), 0);
        tick(10);
        drive(4'h0, 4'b0001, 4'h0); tick(2);
        chk("p12_relock", 32'(bus.o_locked), 1);
        chk("p12_remode", 32'(bus.o_mode),   2);
        chk("p12_reperiod", 32'(bus.o_period), 12);

        // One-cycle reset while locked, then a full relock
        i_reset = 1'b0;
        tick(1);
        chk("mid_locked", 32'(bus.o_locked), 0);
        chk("mid_mode",   32'(bus.o_mode),   0);
        chk("mid_color",  32'(bus.o_color),  0);
        chk("mid_period", 32'(bus.o_period), 0);
        chk("mid_valid",  32'(bus.o_valid),  0);
        i_reset = 1'b1;
        tick(10);
        drive(4'h0, 4'b1000, 4'h0); tick(10);
        drive(4'h0, 4'b0100, 4'h0); tick(2);
        chk("mid_prelock", 32'(bus.o_locked), 0);
        tick(8);
        drive(4'h0, 4'b0010, 4'h0); tick(2);
        chk("mid_relock",  32'(bus.o_locked), 1);
        chk("mid_remode",  32'(bus.o_mode),   2);
        chk("mid_reperiod", 32'(bus.o_period), 10);
        chk("mid_recolor", 32'(bus.o_color),  2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
